// File: rtl/fp_mult_arbiter_if.sv
// rtl/fp_mult_arbiter_if.sv - requester and multiplier signal bundle for fp_mult_arbiter
interface fp_mult_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]    req;
  logic [N*32-1:0] op_a;
  logic [N*32-1:0] op_b;
  logic [N-1:0]    ack;
  logic [N-1:0]    rsp_valid;
  logic [31:0]     rsp_result;
  logic            rsp_timeout;
  logic            busy;
  logic            fp_start;
  logic [31:0]     fp_a;
  logic [31:0]     fp_b;
  logic [31:0]     fp_result;
  logic            fp_done;

  modport slave (
    input  req, op_a, op_b, fp_result, fp_done,
    output ack, rsp_valid, rsp_result, rsp_timeout, busy, fp_start, fp_a, fp_b
  );

  modport master (
    output req, op_a, op_b, fp_result, fp_done,
    input  ack, rsp_valid, rsp_result, rsp_timeout, busy, fp_start, fp_a, fp_b
  );
endinterface

// File: rtl/fp_mult_arbiter.sv
// rtl/fp_mult_arbiter.sv - round-robin sharing of one sequential fp multiplier among N requesters
module fp_mult_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 255
) (
  input logic              clk,
  input logic              rst,
  fp_mult_arbiter_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_t;

  state_t        state, state_d;
  logic [IW-1:0] ptr, ptr_d, winner, winner_d;
  logic [WW-1:0] wd, wd_d;
  logic [N-1:0]  ack_q, ack_d, rv_q, rv_d;
  logic          start_q, start_d, busy_q, busy_d, to_q, to_d;
  logic [31:0]   res_q, res_d, fa_q, fa_d, fb_q, fb_d;
  logic          gnt_found;
  logic [IW-1:0] gnt;
  logic [IW:0]   idx;

  // First requester at or after ptr, wrapping modulo N.
  always_comb begin
    gnt_found = 1'b0;
    gnt       = '0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr} + (IW+1)'(k);
      if (idx >= (IW+1)'(N)) idx = idx - (IW+1)'(N);
      if (!gnt_found && bus.req[idx[IW-1:0]]) begin
        gnt_found = 1'b1;
        gnt       = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state;
    ptr_d    = ptr;
    winner_d = winner;
    wd_d     = '0;
    ack_d    = '0;
    rv_d     = '0;
    start_d  = 1'b0;
    to_d     = 1'b0;
    res_d    = '0;
    fa_d     = fa_q;
    fb_d     = fb_q;
    case (state)
      IDLE: begin
        if (bus.fp_done && gnt_found) begin
          ack_d    = N'(1) << gnt;
          fa_d     = bus.op_a[{gnt, 5'b0} +: 32];
          fb_d     = bus.op_b[{gnt, 5'b0} +: 32];
          winner_d = gnt;
          ptr_d    = (gnt == IW'(N - 1)) ? '0 : gnt + 1'b1;
          start_d  = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!bus.fp_done) begin
          state_d = WAIT_DONE;
        end else if (wd == WW'(TIMEOUT)) begin
          rv_d    = N'(1) << winner;
          to_d    = 1'b1;
          state_d = RESP;
        end else begin
          wd_d = wd + 1'b1;
        end
      end
      WAIT_DONE: begin
        // A completion seen on the deadline cycle still counts as success.
        if (bus.fp_done) begin
          rv_d    = N'(1) << winner;
          res_d   = bus.fp_result;
          state_d = RESP;
        end else if (wd == WW'(TIMEOUT)) begin
          rv_d    = N'(1) << winner;
          to_d    = 1'b1;
          state_d = RESP;
        end else begin
          wd_d = wd + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      winner  <= '0;
      wd      <= '0;
      ack_q   <= '0;
      rv_q    <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
      res_q   <= '0;
      fa_q    <= '0;
      fb_q    <= '0;
    end else begin
      state   <= state_d;
      ptr     <= ptr_d;
      winner  <= winner_d;
      wd      <= wd_d;
      ack_q   <= ack_d;
      rv_q    <= rv_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      to_q    <= to_d;
      res_q   <= res_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
    end
  end

  assign bus.ack         = ack_q;
  assign bus.rsp_valid   = rv_q;
  assign bus.rsp_result  = res_q;
  assign bus.rsp_timeout = to_q;
  assign bus.busy        = busy_q;
  assign bus.fp_start    = start_q;
  assign bus.fp_a        = fa_q;
  assign bus.fp_b        = fb_q;
endmodule

// File: tb/tb_fp_mult_arbiter.sv
// tb/tb_fp_mult_arbiter.sv - self-checking bench for fp_mult_arbiter
module tb_fp_mult_arbiter;
  localparam int N = 4;
  localparam int T = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  fp_mult_arbiter_if #(.N(N)) bus ();
  fp_mult_arbiter #(.N(N), .TIMEOUT(T)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          e;
    logic [47:0] p;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      p = p >> 1;
      e = e + 1;
    end
    return {s, e[7:0], p[45:23]};
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Sequential multiplier stand-in: fp_done falls after start, rises mul_lat+1 cycles later.
  int          mul_lat = 3;
  bit          mul_stuck = 1'b0;
  bit          force_low = 1'b0;
  logic        done_q;
  int          mcnt;
  logic [31:0] mres;
  always @(posedge clk) begin
    if (rst) begin
      done_q <= 1'b1; mcnt <= 0; mres <= '0; bus.fp_result <= '0;
    end else if (mul_stuck) begin
      done_q <= 1'b1;
    end else if (done_q) begin
      if (bus.fp_start) begin
        done_q <= 1'b0; mcnt <= mul_lat; mres <= fmul(bus.fp_a, bus.fp_b);
      end
    end else if (mcnt == 0) begin
      done_q <= 1'b1; bus.fp_result <= mres;
    end else begin
      mcnt <= mcnt - 1;
    end
  end
  assign bus.fp_done = done_q & ~force_low;

  // Transaction model: grant, then two waiting windows each bounded by T elapsed cycles.
  logic [N-1:0] exp_ack = '0, exp_rv = '0, n_ack, n_rv;
  logic         exp_start = 1'b0, exp_busy = 1'b0, exp_to = 1'b0, n_start, n_busy, n_to;
  logic [31:0]  exp_res = '0, n_res, m_a = '0, m_b = '0;
  int           m_ptr = 0, m_win = 0, m_phase = 0, m_ws = 0;
  int           ack_log[$], rsp_log[$];
  int           last_start_cyc = 0, last_rsp_cyc = 0, n_starts = 0;
  logic [31:0]  last_res = '0;
  logic         last_to = 1'b0;

  always @(negedge clk) begin : cmp
    if (rst) begin
      check("rst_ctrl", {bus.ack, bus.rsp_valid, bus.fp_start, bus.busy, bus.rsp_timeout}, 64'd0);
      check("rst_data", {bus.fp_a, bus.fp_b}, 64'd0);
      exp_ack = '0; exp_rv = '0; exp_start = 0; exp_busy = 0; exp_to = 0; exp_res = '0;
      m_ptr = 0; m_a = '0; m_b = '0;
    end else begin
      check("ctrl", {bus.ack, bus.fp_start, bus.busy}, {exp_ack, exp_start, exp_busy});
      check("rsp", {bus.rsp_valid, bus.rsp_timeout, bus.rsp_result}, {exp_rv, exp_to, exp_res});
      if (exp_busy) check("ops", {bus.fp_a, bus.fp_b}, {m_a, m_b});
      if (|bus.ack) ack_log.push_back(oh_idx(bus.ack));
      if (bus.fp_start) begin last_start_cyc = cyc; n_starts++; end
      if (|bus.rsp_valid) begin
        rsp_log.push_back(oh_idx(bus.rsp_valid));
        last_rsp_cyc = cyc; last_res = bus.rsp_result; last_to = bus.rsp_timeout;
      end
      n_ack = '0; n_rv = '0; n_start = 0; n_busy = 0; n_to = 0; n_res = '0;
      if (!exp_busy) begin
        if (bus.fp_done && |bus.req) begin
          for (int k = 0; k < N; k++) begin
            if (!n_start && bus.req[(m_ptr + k) % N]) begin
              m_win = (m_ptr + k) % N;
              n_start = 1;
            end
          end
          m_ptr = (m_win + 1) % N;
          m_a = bus.op_a[32*m_win +: 32];
          m_b = bus.op_b[32*m_win +: 32];
          n_ack[m_win] = 1'b1;
          n_busy = 1;
        end
      end else if (exp_start) begin
        m_phase = 0; m_ws = cyc + 1; n_busy = 1;
      end else if (!(|exp_rv)) begin
        n_busy = 1;
        if (m_phase == 0 && !bus.fp_done) begin
          m_phase = 1; m_ws = cyc + 1;
        end else if (m_phase == 1 && bus.fp_done) begin
          n_rv[m_win] = 1'b1; n_res = fmul(m_a, m_b);
        end else if (cyc - m_ws == T) begin
          n_rv[m_win] = 1'b1; n_to = 1;
        end
      end
      exp_ack = n_ack; exp_rv = n_rv; exp_start = n_start; exp_busy = n_busy;
      exp_to = n_to; exp_res = n_res;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.op_a[32*i +: 32] = a;
    bus.op_b[32*i +: 32] = b;
  endtask

  task automatic issue(input logic [N-1:0] mask, input int n, input int budget);
    int got = 0;
    int b = 0;
    bus.req = mask;
    while (got < n && b < budget) begin
      tick(1); b++;
      if (|bus.ack) got++;
    end
    bus.req = '0;
    check("ack_wait", got, n);
  endtask

  task automatic wait_idle(input int budget);
    int b = 0;
    while (bus.busy && b < budget) begin tick(1); b++; end
    check("idle_wait", bus.busy, 1'b0);
  endtask

  int base, rbase, sbase;
  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    bus.req = '0; bus.op_a = '0; bus.op_b = '0;
    tick(3);
    check("reset_ctrl", {bus.ack, bus.rsp_valid, bus.fp_start, bus.busy, bus.rsp_timeout}, 64'd0);
    check("reset_data", {bus.fp_a, bus.fp_b}, 64'd0);
    check("reset_result", bus.rsp_result, 64'd0);
    rst = 1'b0;
    tick(1);

    // Four requesters held: round-robin from ptr=0.
    for (int i = 0; i < N; i++) set_ops(i, 32'h3F800000 | (i << 21), 32'h40000000 | (i << 20));
    base = ack_log.size(); rbase = rsp_log.size();
    issue(4'b1111, 5, 150);
    wait_idle(40);
    check("t2_acks", ack_log.size() - base, 5);
    check("t2_rsps", rsp_log.size() - rbase, 5);
    if (ack_log.size() - base == 5 && rsp_log.size() - rbase == 5)
      for (int k = 0; k < 5; k++) begin
        check("t2_ack_order", ack_log[base + k], exp_order[k]);
        check("t2_rsp_order", rsp_log[rbase + k], exp_order[k]);
      end

    // Single requester, 2.0 * 3.0.
    set_ops(1, 32'h40000000, 32'h40400000);
    sbase = n_starts; rbase = rsp_log.size();
    issue(4'b0010, 1, 20);
    wait_idle(40);
    check("t1_starts", n_starts - sbase, 1);
    check("t1_rsp_idx", rsp_log[rsp_log.size() - 1], 1);
    check("t1_result", last_res, 32'h40C00000);
    check("t1_timeout", last_to, 1'b0);

    // Round-robin after a grant to 2.
    set_ops(2, 32'h40000000, 32'h40400000);
    base = ack_log.size();
    issue(4'b0100, 1, 20); wait_idle(40);
    issue(4'b1001, 2, 60); wait_idle(40);
    check("t3_n", ack_log.size() - base, 3);
    if (ack_log.size() - base == 3) begin
      check("t3_first", ack_log[base], 2);
      check("t3_second", ack_log[base + 1], 3);
      check("t3_third", ack_log[base + 2], 0);
    end

    // fp_done stuck high: watchdog response 10 cycles after fp_start.
    mul_stuck = 1'b1;
    issue(4'b0001, 1, 20); wait_idle(40);
    check("t4_latency", last_rsp_cyc - last_start_cyc, 10);
    check("t4_timeout", last_to, 1'b1);
    check("t4_result", last_res, 32'h0);
    mul_stuck = 1'b0;
    issue(4'b0010, 1, 20); wait_idle(40);
    check("t4_recover_result", last_res, 32'h40C00000);
    check("t4_recover_timeout", last_to, 1'b0);

    // Completion exactly on the deadline cycle beats the timeout; one cycle later does not.
    mul_lat = T;
    issue(4'b0100, 1, 20); wait_idle(40);
    check("edge_ok_latency", last_rsp_cyc - last_start_cyc, 11);
    check("edge_ok_timeout", last_to, 1'b0);
    check("edge_ok_result", last_res, 32'h40C00000);
    mul_lat = T + 1;
    issue(4'b0100, 1, 20); wait_idle(40);
    check("edge_late_latency", last_rsp_cyc - last_start_cyc, 11);
    check("edge_late_timeout", last_to, 1'b1);
    mul_lat = 3;
    tick(3);

    // Multiplier busy in IDLE: grant waits, captures operands present at grant time.
    force_low = 1'b1;
    set_ops(0, 32'h3FC00000, 32'h40000000);
    base = ack_log.size();
    bus.req = 4'b0001;
    tick(4);
    check("t6_no_ack", ack_log.size() - base, 0);
    set_ops(0, 32'h40200000, 32'h40000000);
    force_low = 1'b0;
    issue(4'b0001, 1, 20);
    set_ops(0, 32'h41000000, 32'h40000000);
    tick(1);
    check("t6_fp_a", bus.fp_a, 32'h40200000);
    wait_idle(40);
    check("t6_result", last_res, 32'h40A00000);

    // Reset while waiting for completion.
    mul_lat = 6;
    rbase = rsp_log.size();
    issue(4'b0010, 1, 20);
    tick(2);
    #2 rst = 1'b1;
    #1;
    check("t5_async_ctrl", {bus.ack, bus.rsp_valid, bus.fp_start, bus.busy, bus.rsp_timeout}, 64'd0);
    check("t5_async_data", {bus.fp_a, bus.fp_b}, 64'd0);
    check("t5_async_result", bus.rsp_result, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    tick(15);
    check("t5_no_rsp", rsp_log.size() - rbase, 0);
    base = ack_log.size();
    issue(4'b1001, 2, 60); wait_idle(40);
    check("t5_n", ack_log.size() - base, 2);
    if (ack_log.size() - base == 2) begin
      check("t5_first_ptr0", ack_log[base], 0);
      check("t5_second", ack_log[base + 1], 3);
    end

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "bench time limit");
  end
endmodule
